// File: rtl/fifo_cmd_rx_if.sv
// Signal bundle between fifo_cmd_rx, the upstream byte FIFO and the payload consumer.
interface fifo_cmd_rx_if;
  logic       fifo_empty;
  logic [7:0] fifo_do;
  logic       fifo_rd;
  logic       dat_rdy;
  logic [7:0] cmd;
  logic       cmd_stb;
  logic [7:0] dat_out;
  logic       dat_stb;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic       busy;

  modport slave (
    input  fifo_empty, fifo_do, dat_rdy,
    output fifo_rd, cmd, cmd_stb, dat_out, dat_stb, frm_ok, frm_err, err_code, busy
  );

  modport master (
    output fifo_empty, fifo_do, dat_rdy,
    input  fifo_rd, cmd, cmd_stb, dat_out, dat_stb, frm_ok, frm_err, err_code, busy
  );
endinterface

// File: rtl/fifo_cmd_rx.sv
// Command frame receiver: pops bytes from a show-ahead FIFO, parses
// sync/cmd/~cmd/len/payload/xor-checksum frames and reports frame status.
module fifo_cmd_rx #(
  parameter int RD_GAP = 3,
  parameter int TOUT   = 50000
) (
  input  logic          clk,
  input  logic          rst,
  fifo_cmd_rx_if.slave  bus
);
  localparam logic [7:0]       SYNC   = 8'h2B;
  localparam int               GAP_W  = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(RD_GAP);
  localparam logic [GAP_W-1:0] GAP_1  = GAP_W'(1);
  localparam logic [31:0]      TOUT_L = 32'(TOUT);

  typedef enum logic [2:0] {HUNT, CMD, NCMD, LEN, DATA, SUM} state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      tout_cnt;
  logic [7:0]       len_cnt;
  logic [7:0]       csum;
  logic [7:0]       cmd_lat;
  logic             stall;
  logic             fetch;
  logic             tout_run;
  logic             tout_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A payload stall freezes both popping and the inter-byte timer.
  always_comb begin
    stall    = (state == DATA) && !bus.dat_rdy;
    fetch    = !bus.fifo_empty && (gap_cnt == '0) && !stall;
    tout_run = (state != HUNT) && bus.fifo_empty && !stall;
    tout_hit = tout_run && (({16'd0, tout_cnt} + 32'd1) >= TOUT_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      gap_cnt      <= '0;
      tout_cnt     <= '0;
      len_cnt      <= '0;
      csum         <= '0;
      cmd_lat      <= '0;
      bus.fifo_rd  <= 1'b0;
      bus.cmd      <= 8'h00;
      bus.cmd_stb  <= 1'b0;
      bus.dat_out  <= 8'h00;
      bus.dat_stb  <= 1'b0;
      bus.frm_ok   <= 1'b0;
      bus.frm_err  <= 1'b0;
      bus.err_code <= 2'd0;
      bus.busy     <= 1'b0;
    end else begin
      bus.fifo_rd <= fetch;
      bus.cmd_stb <= 1'b0;
      bus.dat_stb <= 1'b0;
      bus.frm_ok  <= 1'b0;
      bus.frm_err <= 1'b0;

      if (fetch)
        gap_cnt <= GAP_LD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_1;

      if (fetch || state == HUNT)
        tout_cnt <= '0;
      else if (tout_run)
        tout_cnt <= sat_inc(tout_cnt);

      // The fetched byte is consumed straight from the show-ahead head.
      if (fetch) begin
        case (state)
          HUNT: begin
            if (bus.fifo_do == SYNC) begin
              state    <= CMD;
              bus.busy <= 1'b1;
            end
          end
          CMD: begin
            cmd_lat <= bus.fifo_do;
            state   <= NCMD;
          end
          NCMD: begin
            if (bus.fifo_do == ~cmd_lat) begin
              bus.cmd     <= cmd_lat;
              bus.cmd_stb <= 1'b1;
              state       <= LEN;
            end else begin
              bus.frm_err  <= 1'b1;
              bus.err_code <= 2'd1;
              state        <= HUNT;
              bus.busy     <= 1'b0;
            end
          end
          LEN: begin
            len_cnt <= bus.fifo_do;
            csum    <= cmd_lat;
            state   <= (bus.fifo_do == 8'h00) ? SUM : DATA;
          end
          DATA: begin
            bus.dat_out <= bus.fifo_do;
            bus.dat_stb <= 1'b1;
            csum        <= csum ^ bus.fifo_do;
            len_cnt     <= len_cnt - 8'd1;
            if (len_cnt == 8'd1)
              state <= SUM;
          end
          SUM: begin
            if (bus.fifo_do == csum) begin
              bus.frm_ok <= 1'b1;
            end else begin
              bus.frm_err  <= 1'b1;
              bus.err_code <= 2'd2;
            end
            state    <= HUNT;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= HUNT;
            bus.busy <= 1'b0;
          end
        endcase
      end else if (tout_hit) begin
        bus.frm_err  <= 1'b1;
        bus.err_code <= 2'd3;
        state        <= HUNT;
        bus.busy     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_cmd_rx.sv
// Randomized bench for fifo_cmd_rx: a byte-level frame parser predicts the
// event stream, which is compared against strobes observed on the DUT.
module tb_fifo_cmd_rx;
  localparam int RD_GAP = 3;
  localparam int TOUT   = 100;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_cmd_rx_if bus();

  fifo_cmd_rx #(.RD_GAP(RD_GAP), .TOUT(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  bq_t  fq;
  int   exp_q[$];
  int   obs_q[$];
  int   ncyc = 0;
  int   last_rd = -100;
  int   last_err_cyc = 0;
  int   rd_cnt = 0;
  bit   rnd_rdy = 1'b0;
  logic rdy_man = 1'b1;
  logic rdy_rand = 1'b1;

  assign bus.dat_rdy = rnd_rdy ? rdy_rand : rdy_man;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // FIFO model, event monitor and random back-pressure, all on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (bus.fifo_rd) begin
      rd_cnt++;
      chk("rd_spacing", (ncyc - last_rd) >= (RD_GAP + 1), 1);
      last_rd = ncyc;
      if (fq.size() == 0) chk("rd_from_empty", 1, 0);
      else fq.delete(0);
    end
    if (bus.cmd_stb) obs_q.push_back(32'h100 | bus.cmd);
    if (bus.dat_stb) obs_q.push_back(32'h200 | bus.dat_out);
    if (bus.frm_ok)  obs_q.push_back(32'h300);
    if (bus.frm_err) begin
      obs_q.push_back(32'h400 | bus.err_code);
      last_err_cyc = ncyc;
    end
    if (bus.frm_ok || bus.frm_err) chk("ok_err_exclusive", bus.frm_ok & bus.frm_err, 0);
    rdy_rand = ($urandom_range(0, 3) != 0);
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_do    = (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Frame-level reference: walks the byte stream and lists the expected events.
  function automatic void model(input bq_t s);
    int i, n, len;
    logic [7:0] c, nc, sum;
    i = 0;
    n = s.size();
    while (i < n) begin
      if (s[i] != 8'h2B) begin
        i++;
        continue;
      end
      i++;
      if (i + 2 > n) begin exp_q.push_back(32'h403); break; end
      c  = s[i];
      nc = s[i+1];
      i += 2;
      if (nc != ~c) begin exp_q.push_back(32'h401); continue; end
      exp_q.push_back(32'h100 | c);
      if (i >= n) begin exp_q.push_back(32'h403); break; end
      len = int'(s[i]);
      i++;
      sum = c;
      if (i + len + 1 > n) begin
        while (i < n) begin exp_q.push_back(32'h200 | s[i]); i++; end
        exp_q.push_back(32'h403);
        break;
      end
      for (int k = 0; k < len; k++) begin
        exp_q.push_back(32'h200 | s[i]);
        sum = sum ^ s[i];
        i++;
      end
      exp_q.push_back((s[i] == sum) ? 32'h300 : 32'h402);
      i++;
    end
  endfunction

  task automatic run(input string tag, input bq_t s, input int stall);
    int rd0, budget, r0, e0;
    bit stalled;
    rd0 = rd_cnt;
    stalled = 1'b0;
    exp_q.delete();
    obs_q.delete();
    model(s);
    foreach (s[k]) fq.push_back(s[k]);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
      if (stall > 0 && !stalled && obs_q.size() >= 2) begin
        stalled = 1'b1;
        rdy_man = 1'b0;
        r0 = rd_cnt;
        e0 = obs_q.size();
        repeat (stall) @(negedge clk);
        chk({tag, "_stall_pop"}, rd_cnt - r0, 0);
        chk({tag, "_stall_event"}, obs_q.size() - e0, 0);
        chk({tag, "_stall_busy"}, bus.busy, 1);
        rdy_man = 1'b1;
      end
    end while (!(fq.size() == 0 && !bus.busy) && budget < 20000);
    repeat (8) @(negedge clk);
    chk({tag, "_done"}, budget < 20000, 1);
    chk({tag, "_rd_cnt"}, rd_cnt - rd0, s.size());
    chk({tag, "_n_events"}, obs_q.size(), exp_q.size());
    foreach (exp_q[k]) chk({tag, "_event"}, (k < obs_q.size()) ? obs_q[k] : -1, exp_q[k]);
    chk({tag, "_busy_idle"}, bus.busy, 0);
  endtask

  initial begin
    bq_t s;
    logic [7:0] c, nc, d, sum;
    int len, kind, nfr, cut, b;

    repeat (3) @(negedge clk);
    chk("rst_fifo_rd", bus.fifo_rd, 0);
    chk("rst_cmd_stb", bus.cmd_stb, 0);
    chk("rst_dat_stb", bus.dat_stb, 0);
    chk("rst_frm_ok", bus.frm_ok, 0);
    chk("rst_frm_err", bus.frm_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmd", bus.cmd, 8'h00);
    chk("rst_dat_out", bus.dat_out, 8'h00);
    chk("rst_err_code", bus.err_code, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    s = '{8'h2B, 8'h10, 8'hEF, 8'h02, 8'hAA, 8'h55, 8'hEF};
    run("basic", s, 0);
    chk("basic_cmd", bus.cmd, 8'h10);
    chk("basic_err_code", bus.err_code, 0);

    s = '{8'h00, 8'h7F, 8'h2B, 8'h05, 8'hFA, 8'h00, 8'h05};
    run("len0", s, 0);
    chk("len0_cmd", bus.cmd, 8'h05);

    s = '{8'h2B, 8'h10, 8'hEE, 8'h2B, 8'h20, 8'hDF, 8'h00, 8'h20};
    run("badncmd", s, 0);
    chk("badncmd_err_held", bus.err_code, 1);
    chk("badncmd_cmd", bus.cmd, 8'h20);

    s = '{8'h2B, 8'h10, 8'hEF, 8'h01, 8'hAA, 8'h00};
    run("badsum", s, 0);
    chk("badsum_err_code", bus.err_code, 2);

    s = '{8'h2B, 8'h10, 8'hEF, 8'h03, 8'h11};
    run("timeout", s, 0);
    chk("timeout_latency", last_err_cyc - last_rd, TOUT);
    chk("timeout_err_code", bus.err_code, 3);

    s = '{8'h2B, 8'h10, 8'hEF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h10};
    run("stall", s, 500);

    // Reset mid-payload abandons the frame silently.
    s = '{8'h2B, 8'h30, 8'hCF, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h37};
    foreach (s[k]) fq.push_back(s[k]);
    b = 0;
    do begin @(negedge clk); b++; end while (!bus.cmd_stb && b < 200);
    chk("midrst_cmd_seen", b < 200, 1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_fifo_rd", bus.fifo_rd, 0);
      chk("midrst_frm_err", bus.frm_err, 0);
      chk("midrst_busy", bus.busy, 0);
    end
    fq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_cmd_cleared", bus.cmd, 8'h00);
    chk("midrst_err_cleared", bus.err_code, 0);
    chk("midrst_idle", bus.busy, 0);

    rnd_rdy = 1'b1;
    for (int it = 0; it < 25; it++) begin
      s.delete();
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        repeat ($urandom_range(0, 2)) s.push_back(8'($urandom_range(0, 255)));
        c = 8'($urandom_range(0, 255));
        kind = $urandom_range(0, 9);
        nc = ~c;
        if (kind == 0) nc = nc ^ (8'h01 << $urandom_range(0, 7));
        s.push_back(8'h2B);
        s.push_back(c);
        s.push_back(nc);
        len = (it == 3 && f == 0) ? 255 : $urandom_range(0, 10);
        s.push_back(8'(len));
        sum = c;
        for (int k = 0; k < len; k++) begin
          d = ($urandom_range(0, 7) == 0) ? 8'h2B : 8'($urandom_range(0, 255));
          s.push_back(d);
          sum = sum ^ d;
        end
        s.push_back((kind == 1) ? (sum ^ 8'h5A) : sum);
      end
      if ($urandom_range(0, 4) == 0) begin
        cut = $urandom_range(1, s.size() - 1);
        repeat (cut) void'(s.pop_back());
      end
      run("rand", s, 0);
    end
    rnd_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_cmd_rx.md
FIFO_CMD_RX -- requirements
Module: fifo_cmd_rx

Interface
REQ-001 Parameter RD_GAP, default 3, meaning idle cycles after each fifo_rd pulse before fifo_empty/fifo_do are trusted again (covers the FIFO's pointer-update latency).
REQ-002 Parameter TOUT, default 50000, meaning the maximum number of clk cycles allowed between bytes inside a frame.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 fifo_empty  in  1  high when the upstream ARM-to-CPU FIFO holds no byte.
REQ-007 fifo_do  in  8  show-ahead head byte of the FIFO; valid while fifo_empty=0.
REQ-008 fifo_rd  out  1  one-cycle pop strobe to the FIFO.
REQ-009 dat_rdy  in  1  downstream consumer can accept a payload byte.
REQ-010 cmd  out  8  command code of the current frame; held until the next header.
REQ-011 cmd_stb  out  1  one-cycle pulse when cmd is validated.
REQ-012 dat_out, dat_stb  out  8, 1  payload byte and its one-cycle qualifier.
REQ-013 frm_ok, frm_err  out  1, 1  one-cycle end-of-frame status pulses.
REQ-014 err_code  out  2  0=none, 1=cmd complement mismatch, 2=checksum, 3=timeout; held until the next frame error or reset.
REQ-015 busy  out  1  high in every state except HUNT.

Function
REQ-016 Frame format: 0x2B sync, cmd, ~cmd, len (0..255), then len payload bytes, then a checksum byte equal to the XOR of cmd and all payload bytes.
REQ-017 Byte fetch: when fifo_empty=0 and the gap counter is 0, the block SHALL sample fifo_do, assert fifo_rd for exactly one cycle in that same cycle, then load the gap counter with RD_GAP.
REQ-018 No further fifo_rd SHALL occur while the gap counter is nonzero; the counter decrements by 1 per cycle.
REQ-019 States: HUNT, CMD, NCMD, LEN, DATA, SUM.
REQ-020 HUNT: fetch bytes; discard any byte other than 0x2B; on 0x2B go to CMD.
REQ-021 CMD: latch the fetched byte into an internal register and go to NCMD.
REQ-022 NCMD: if the byte equals ~latched cmd, update the cmd output, pulse cmd_stb for one cycle and go to LEN; otherwise pulse frm_err with err_code=1 and go to HUNT.
REQ-023 LEN: load an 8-bit remaining-byte counter and clear the running checksum to cmd; go to DATA if len != 0, else to SUM.
REQ-024 DATA: fetch only while dat_rdy=1.
REQ-025 DATA, per fetched byte: drive dat_out, pulse dat_stb for one cycle in the fetch cycle, XOR the byte into the checksum and decrement the counter.
REQ-026 DATA: when the counter reaches 0, go to SUM.
REQ-027 dat_rdy=0 stalls DATA; the stall SHALL NOT pop the FIFO and SHALL NOT advance the timeout counter.
REQ-028 SUM: on a checksum match pulse frm_ok; on a mismatch pulse frm_err with err_code=2; then go to HUNT in both cases.
REQ-029 Timeout: a 16-bit counter clears on every fifo_rd and counts while busy=1 and the FIFO is empty.
REQ-030 Timeout: when the counter reaches TOUT, the block SHALL pulse frm_err with err_code=3 and go to HUNT.
REQ-031 Timeout counter: in HUNT it is held at 0; it SHALL saturate and never wrap.
REQ-032 Simultaneous events: a timeout expiring in the same cycle as a fetch SHALL lose to the fetch.
REQ-033 frm_ok and frm_err SHALL never be high in the same cycle.
REQ-034 A sync byte 0x2B arriving inside a frame is ordinary data, with no resynchronisation.
REQ-035 len=255 SHALL deliver exactly 255 dat_stb pulses; the counter SHALL NOT wrap.
REQ-036 All outputs are registered; minimum byte-to-byte spacing is RD_GAP+1 cycles.

Reset
REQ-037 While rst is high: state=HUNT; gap, timeout and length counters = 0; checksum=0.
REQ-038 While rst is high: fifo_rd, cmd_stb, dat_stb, frm_ok, frm_err, busy = 0; cmd=0x00, dat_out=0x00, err_code=0.
REQ-039 Reset asserted mid-frame SHALL abandon the frame with no frm_err pulse and no FIFO pop in the reset cycle.

Verification
REQ-040 FIFO holds 2B 10 EF 02 AA 55 EF -> cmd_stb with cmd=0x10; dat_stb with AA then 55; frm_ok; busy low after; exactly 7 fifo_rd pulses.
REQ-041 FIFO holds 00 7F 2B 05 FA 00 05 -> first two bytes discarded; cmd=0x05; no dat_stb; frm_ok.
REQ-042 FIFO holds 2B 10 EE -> frm_err with err_code=1; no cmd_stb; next byte 2B is accepted as a new sync.
REQ-043 FIFO holds 2B 10 EF 01 AA 00 -> dat_stb with AA; frm_err with err_code=2 (expected checksum BA).
REQ-044 TOUT=100, FIFO holds 2B 10 EF 03 11 and then runs empty -> frm_err with err_code=3 exactly 100 cycles after the last fifo_rd; state HUNT.
REQ-045 dat_rdy held low for 500 cycles mid-payload with TOUT=100 -> no timeout and no pop; release dat_rdy -> frame completes with frm_ok.
